mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-ported 16-bit unified memory between the multi-cycle CPU control/datapath (instruction fetch and lw/sw via IoD) and an external requester (loader/debug/IO master).
- Sequences each access over a configurable memory latency and returns read data.
- Acknowledges the requester; the CPU control FSM stalls in its current state until ack.
- Sits between the datapath memory interface and the memory macro.

Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MEM_LAT, 1, cycles mem_re/mem_we are held per access; legal range 1..7; mem_rdata is valid in the last of these cycles

Ports:
- CLK  input  1  clock, rising edge
- Reset  input  1  asynchronous, active-high
- cpu_req  input  1  CPU access request; held until cpu_ack
- cpu_we  input  1  1 = write (sw), 0 = read (fetch/lw)
- cpu_addr  input  ADDR_W  CPU address (PC or ALUOut per IoD)
- cpu_wdata  input  DATA_W  CPU store data
- cpu_rdata  output  DATA_W  registered CPU read data
- cpu_ack  output  1  one-cycle completion pulse
- ext_req  input  1  external request; held until ext_ack
- ext_we  input  1  external write enable
- ext_addr  input  ADDR_W  external address
- ext_wdata  input  DATA_W  external store data
- ext_rdata  output  DATA_W  registered external read data
- ext_ack  output  1  one-cycle completion pulse
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data
- mem_re  output  1  memory read strobe
- mem_we  output  1  memory write strobe
- busy  output  1  high in every state except IDLE
- grant_ext  output  1  high while the external requester owns the memory (ACC or DONE)

Behaviour:
- Reset (async): state IDLE; lat_cnt = 0; starve_cnt = 0.
  - Outputs: cpu_rdata = 0, ext_rdata = 0, cpu_ack = 0, ext_ack = 0, mem_re = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, busy = 0, grant_ext = 0.
  - Reset mid-access aborts the access immediately: mem_we/mem_re drop asynchronously and no ack is issued.
- All outputs are registered.
- States: IDLE, ACC, DONE.
- IDLE:
  - If any req is high, grant one, latch owner/we/addr/wdata, load lat_cnt = MEM_LAT-1, go to ACC.
  - Arbitration: fixed priority, CPU over ext.
  - If no req, stay in IDLE.
- ACC:
  - Drive the latched mem_addr/mem_wdata with mem_re = !we or mem_we = we, held for exactly MEM_LAT cycles.
  - lat_cnt decrements each cycle.
  - When lat_cnt == 0: on a read, capture mem_rdata into the owner's rdata register; go to DONE.
- DONE:
  - mem_re = mem_we = 0; the owner's ack = 1 for exactly one cycle; go to IDLE.
- Latency: req sampled high in IDLE at edge N → ack high in cycle N+MEM_LAT+1 (MEM_LAT=1: ack 2 cycles after the grant edge).
- Minimum spacing between grants: MEM_LAT+2 cycles; one IDLE cycle always separates accesses.
- Requester protocol:
  - Requester deasserts req (or presents a new request) on the edge after ack.
  - A req still high in IDLE is a new request.
  - req/addr/wdata changes during ACC are ignored (latched).
  - Dropping req mid-access does not cancel; the ack is still pulsed.
- rdata registers hold their value until the same requester's next read completes; writes never modify rdata.
- Simultaneous cpu_req and ext_req in IDLE: CPU wins; ext stays pending (see the optional feature).
- A new request arriving during ACC/DONE waits for IDLE.
- The memory is never driven with both mem_re and mem_we high.
- MEM_LAT outside 1..7: elaboration error.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- Defined:
  - 2-bit starve_cnt counts consecutive CPU grants made while ext_req was high.
  - When starve_cnt == 3 and both requests are pending in IDLE, ext is granted and starve_cnt clears.
  - Any ext grant, or any CPU grant with ext_req low, clears starve_cnt.
- Not defined: pure fixed CPU priority; starve_cnt is absent; ext may starve indefinitely.

Test Plan:
- Reset mid-ACC with mem_we=1 → mem_we=0 immediately; no ack; state IDLE; busy=0; rdata=0.
- MEM_LAT=1: cpu_req read, addr 0x0010, mem returns 0xBEEF → mem_re high 1 cycle; cpu_ack pulses 2 cycles after grant; cpu_rdata=0xBEEF; ext_rdata unchanged.
- MEM_LAT=3: ext write, addr 0x0200, data 0x1234 → mem_we high exactly 3 cycles at 0x0200/0x1234; grant_ext=1 through DONE; ext_ack single pulse; ext_rdata unchanged.
- cpu_req and ext_req raised in the same cycle (both reads) → CPU served first; ext granted after the IDLE gap; each ack 1 cycle; rdata values routed to the correct requester.
- cpu_req held continuously with ext_req high, guard defined → grants C,C,C,E,C…; guard undefined → ext never granted while cpu_req is high.
- ext drops ext_req during ACC → access completes, ext_ack still pulses once, then IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported unified memory between the multi-cycle CPU
//   (instruction fetch and lw/sw) and an external requester (loader, debug
//   or IO master). Each access holds mem_re/mem_we for MEM_LAT cycles.
//   Read data is captured in the last of those cycles. A one-cycle ack
//   then goes to the requester that owns the access.
//
//   Ports
//     CLK, Reset                     clock (rising edge), async active-high reset
//     cpu_req/we/addr/wdata          CPU request, held until cpu_ack
//     cpu_rdata, cpu_ack             registered CPU read data, completion pulse
//     ext_req/we/addr/wdata          external request, held until ext_ack
//     ext_rdata, ext_ack             registered external read data, completion pulse
//     mem_addr/wdata/re/we           memory macro interface (all registered)
//     mem_rdata                      memory read data
//     busy                           high whenever an access is in flight (ACC/DONE)
//     grant_ext                      high while the external requester owns the memory
//
//   Optional build macro: ARB_STARVE_GUARD_EN
//     When defined, after three consecutive CPU grants made while ext_req
//     was pending, the external requester is granted ahead of the CPU.
//     When undefined, the CPU always has fixed priority.

module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic              busy,
  output logic              grant_ext
);

  generate
    if (MEM_LAT == 0 || MEM_LAT > 7) begin : g_bad_mem_lat
      $error("mem_port_arbiter: MEM_LAT must be in 1..7");
    end
  endgenerate

  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        lat_cnt_q, lat_cnt_d;
  logic              owner_ext_q, owner_ext_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              ext_ack_q, ext_ack_d;
  logic              busy_q, busy_d;
  logic              grant_ext_q, grant_ext_d;
`ifdef ARB_STARVE_GUARD_EN
  logic [1:0]        starve_cnt_q, starve_cnt_d;
`endif

  logic take_ext;
  logic sel_we;

  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    owner_ext_d = owner_ext_q;
    we_d        = we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_re_d    = mem_re_q;
    mem_we_d    = mem_we_q;
    cpu_rdata_d = cpu_rdata_q;
    ext_rdata_d = ext_rdata_q;
    cpu_ack_d   = 1'b0;
    ext_ack_d   = 1'b0;
    busy_d      = busy_q;
    grant_ext_d = grant_ext_q;
`ifdef ARB_STARVE_GUARD_EN
    starve_cnt_d = starve_cnt_q;
    // ext wins if the CPU is absent, or if it has been passed over three times in a row
    take_ext = ext_req && (!cpu_req || (starve_cnt_q == 2'd3));
`else
    take_ext = ext_req && !cpu_req;
`endif
    sel_we = take_ext ? ext_we : cpu_we;

    unique case (state_q)
      ST_IDLE: begin
        if (cpu_req || ext_req) begin
          state_d     = ST_ACC;
          lat_cnt_d   = LAT_LOAD;
          owner_ext_d = take_ext;
          we_d        = sel_we;
          mem_addr_d  = take_ext ? ext_addr  : cpu_addr;
          mem_wdata_d = take_ext ? ext_wdata : cpu_wdata;
          mem_re_d    = !sel_we;
          mem_we_d    = sel_we;
          busy_d      = 1'b1;
          grant_ext_d = take_ext;
`ifdef ARB_STARVE_GUARD_EN
          if (take_ext || !ext_req) begin
            starve_cnt_d = '0;
          end else begin
            starve_cnt_d = starve_cnt_q + 2'd1;
          end
`endif
        end
      end
      ST_ACC: begin
        if (lat_cnt_q == 3'd0) begin
          state_d  = ST_DONE;
          mem_re_d = 1'b0;
          mem_we_d = 1'b0;
          if (!we_q) begin
            if (owner_ext_q) ext_rdata_d = mem_rdata;
            else             cpu_rdata_d = mem_rdata;
          end
          cpu_ack_d = !owner_ext_q;
          ext_ack_d = owner_ext_q;
        end else begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        busy_d      = 1'b0;
        grant_ext_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      lat_cnt_q    <= '0;
      owner_ext_q  <= 1'b0;
      we_q         <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      cpu_rdata_q  <= '0;
      ext_rdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
      ext_ack_q    <= 1'b0;
      busy_q       <= 1'b0;
      grant_ext_q  <= 1'b0;
`ifdef ARB_STARVE_GUARD_EN
      starve_cnt_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      owner_ext_q  <= owner_ext_d;
      we_q         <= we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ext_rdata_q  <= ext_rdata_d;
      cpu_ack_q    <= cpu_ack_d;
      ext_ack_q    <= ext_ack_d;
      busy_q       <= busy_d;
      grant_ext_q  <= grant_ext_d;
`ifdef ARB_STARVE_GUARD_EN
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign ext_rdata = ext_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign ext_ack   = ext_ack_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign busy      = busy_q;
  assign grant_ext = grant_ext_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: main instance at MEM_LAT=3, second at MEM_LAT=1.
module tb_mem_port_arbiter;

  localparam int unsigned LAT = 3;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_ack;
  logic        ext_req = 1'b0, ext_we = 1'b0;
  logic [15:0] ext_addr = '0, ext_wdata = '0;
  logic [15:0] ext_rdata;
  logic        ext_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_re, mem_we, busy, grant_ext;

  logic        l1_cpu_req = 1'b0;
  logic [15:0] l1_cpu_addr = '0;
  logic        l1_zero = 1'b0;
  logic [15:0] l1_zero16 = '0;
  logic [15:0] l1_cpu_rdata, l1_ext_rdata, l1_mem_addr, l1_mem_wdata, l1_mem_rdata;
  logic        l1_cpu_ack, l1_ext_ack, l1_mem_re, l1_mem_we, l1_busy, l1_grant_ext;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) u_dut (
    .CLK(CLK), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_ack(ext_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .busy(busy), .grant_ext(grant_ext)
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u_dut_lat1 (
    .CLK(CLK), .Reset(Reset),
    .cpu_req(l1_cpu_req), .cpu_we(l1_zero), .cpu_addr(l1_cpu_addr), .cpu_wdata(l1_zero16),
    .cpu_rdata(l1_cpu_rdata), .cpu_ack(l1_cpu_ack),
    .ext_req(l1_zero), .ext_we(l1_zero), .ext_addr(l1_zero16), .ext_wdata(l1_zero16),
    .ext_rdata(l1_ext_rdata), .ext_ack(l1_ext_ack),
    .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata), .mem_rdata(l1_mem_rdata),
    .mem_re(l1_mem_re), .mem_we(l1_mem_we), .busy(l1_busy), .grant_ext(l1_grant_ext)
  );

  // Memory model: fixed background pattern, overwritten by DUT writes.
  function automatic logic [15:0] pat(input logic [7:0] a);
    return (a == 8'h10) ? 16'hBEEF : {a ^ 8'h5A, a};
  endfunction

  logic [15:0] wmem [256];
  bit          wvalid [256];
  always @(posedge CLK) begin
    if (mem_we) begin
      wmem[mem_addr[7:0]]   <= mem_wdata;
      wvalid[mem_addr[7:0]] <= 1'b1;
    end
  end
  always_comb mem_rdata = wvalid[mem_addr[7:0]] ? wmem[mem_addr[7:0]] : pat(mem_addr[7:0]);
  always_comb l1_mem_rdata = pat(l1_mem_addr[7:0]);

  // Reference model and scoreboard
  logic [15:0] ref_wr [logic [7:0]];
  logic [15:0] cpu_model = '0, ext_model = '0;
  logic [15:0] cpu_exp_q[$], ext_exp_q[$];
  logic        grant_log[$];
  int          grant_cyc[$];
  int          checks = 0, errors = 0;
  int          cyc = 0, run = 0, last_run = 0;
  logic        prev_strobe = 1'b0;

  function automatic logic [15:0] ref_rd(input logic [7:0] a);
    return ref_wr.exists(a) ? ref_wr[a] : pat(a);
  endfunction

  task automatic push_exp(input bit is_ext, input bit we, input logic [15:0] a, input logic [15:0] d);
    if (we) ref_wr[a[7:0]] = d;
    else if (is_ext) ext_model = ref_rd(a[7:0]);
    else cpu_model = ref_rd(a[7:0]);
    if (is_ext) ext_exp_q.push_back(ext_model);
    else cpu_exp_q.push_back(cpu_model);
  endtask

  function automatic logic [15:0] pop_cpu();
    return (cpu_exp_q.size() != 0) ? cpu_exp_q.pop_front() : 16'hxxxx;
  endfunction
  function automatic logic [15:0] pop_ext();
    return (ext_exp_q.size() != 0) ? ext_exp_q.pop_front() : 16'hxxxx;
  endfunction
  function automatic logic pop_grant(output int c);
    c = (grant_cyc.size() != 0) ? grant_cyc.pop_front() : -1;
    return (grant_log.size() != 0) ? grant_log.pop_front() : 1'bx;
  endfunction

  task automatic issue_cpu(input bit we, input logic [15:0] a, input logic [15:0] d);
    cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    push_exp(1'b0, we, a, d);
  endtask
  task automatic issue_ext(input bit we, input logic [15:0] a, input logic [15:0] d);
    ext_we = we; ext_addr = a; ext_wdata = d; ext_req = 1'b1;
    push_exp(1'b1, we, a, d);
  endtask

  // One sampling point per cycle (negedge); logs grant owner and strobe run lengths.
  task automatic tick();
    logic strobe;
    @(negedge CLK);
    cyc++;
    strobe = mem_re | mem_we;
    if (strobe && !prev_strobe) begin
      grant_log.push_back(grant_ext);
      grant_cyc.push_back(cyc);
    end
    if (strobe) run++;
    else if (run != 0) begin last_run = run; run = 0; end
    prev_strobe = strobe;
  endtask

  task automatic wait_ack(input bit is_ext, input int budget, output int n, output bit got);
    n = 0; got = 1'b0;
    while (!got && n < budget) begin
      tick(); n++;
      got = is_ext ? ext_ack : cpu_ack;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; tick(); tick();
    checks++; if ({cpu_ack, ext_ack, mem_re, mem_we, busy, grant_ext} !== 6'b0) begin errors++;
      $display("FAIL reset_ctrl: got %b expected 000000", {cpu_ack, ext_ack, mem_re, mem_we, busy, grant_ext}); end
    checks++; if (cpu_rdata !== 16'h0) begin errors++; $display("FAIL reset_cpu_rdata: got %h expected 0000", cpu_rdata); end
    checks++; if (ext_rdata !== 16'h0) begin errors++; $display("FAIL reset_ext_rdata: got %h expected 0000", ext_rdata); end
    checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0000", mem_addr); end
    checks++; if (mem_wdata !== 16'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 0000", mem_wdata); end
    Reset = 1'b0; tick();
  endtask

  task automatic test_lat1_read();
    int n = 0, re_cnt = 0;
    l1_cpu_addr = 16'h0010; l1_cpu_req = 1'b1;
    while (!l1_cpu_ack && n < 10) begin
      tick(); n++;
      if (l1_mem_re) re_cnt++;
    end
    l1_cpu_req = 1'b0;
    checks++; if (n !== 2) begin errors++; $display("FAIL lat1_ack_latency: got %0d expected 2", n); end
    checks++; if (re_cnt !== 1) begin errors++; $display("FAIL lat1_re_cycles: got %0d expected 1", re_cnt); end
    checks++; if (l1_cpu_rdata !== 16'hBEEF) begin errors++; $display("FAIL lat1_cpu_rdata: got %h expected beef", l1_cpu_rdata); end
    checks++; if (l1_ext_rdata !== 16'h0) begin errors++; $display("FAIL lat1_ext_rdata: got %h expected 0000", l1_ext_rdata); end
    tick();
    checks++; if ({l1_cpu_ack, l1_busy} !== 2'b00) begin errors++; $display("FAIL lat1_ack_pulse: got %b expected 00", {l1_cpu_ack, l1_busy}); end
  endtask

  task automatic test_cpu_read();
    int n, c; bit got; logic [15:0] exp; logic g;
    last_run = 0;
    issue_cpu(1'b0, 16'h0010, 16'h0);
    wait_ack(1'b0, 20, n, got); cpu_req = 1'b0;
    checks++; if (!got) begin errors++; $display("FAIL cpu_read_ack: got timeout expected ack"); end
    checks++; if (n !== LAT + 1) begin errors++; $display("FAIL cpu_read_latency: got %0d expected %0d", n, LAT + 1); end
    checks++; if (last_run !== LAT) begin errors++; $display("FAIL cpu_read_re_len: got %0d expected %0d", last_run, LAT); end
    exp = pop_cpu();
    checks++; if (cpu_rdata !== exp) begin errors++; $display("FAIL cpu_read_rdata: got %h expected %h", cpu_rdata, exp); end
    checks++; if (ext_rdata !== ext_model) begin errors++; $display("FAIL cpu_read_ext_rdata: got %h expected %h", ext_rdata, ext_model); end
    g = pop_grant(c);
    checks++; if (g !== 1'b0) begin errors++; $display("FAIL cpu_read_owner: got %b expected 0", g); end
    tick();
    checks++; if ({cpu_ack, busy} !== 2'b00) begin errors++; $display("FAIL cpu_read_pulse: got %b expected 00", {cpu_ack, busy}); end
  endtask

  task automatic test_ext_write();
    int n = 0, c; bit got = 1'b0; logic [15:0] exp; logic g;
    last_run = 0;
    issue_ext(1'b1, 16'h0200, 16'h1234);
    while (!got && n < 20) begin
      tick(); n++;
      if (mem_we) begin
        checks++;
        if ({mem_addr, mem_wdata, mem_re, grant_ext} !== {16'h0200, 16'h1234, 1'b0, 1'b1}) begin errors++;
          $display("FAIL ext_write_bus: got %h/%h re=%b g=%b expected 0200/1234 re=0 g=1", mem_addr, mem_wdata, mem_re, grant_ext); end
      end
      got = ext_ack;
    end
    ext_req = 1'b0;
    checks++; if (!got || n !== LAT + 1) begin errors++; $display("FAIL ext_write_ack: got n=%0d ack=%b expected n=%0d ack=1", n, got, LAT + 1); end
    checks++; if (last_run !== LAT) begin errors++; $display("FAIL ext_write_we_len: got %0d expected %0d", last_run, LAT); end
    checks++; if (grant_ext !== 1'b1) begin errors++; $display("FAIL ext_write_grant_done: got %b expected 1", grant_ext); end
    exp = pop_ext();
    checks++; if (ext_rdata !== exp) begin errors++; $display("FAIL ext_write_rdata: got %h expected %h", ext_rdata, exp); end
    checks++; if (cpu_rdata !== cpu_model) begin errors++; $display("FAIL ext_write_cpu_rdata: got %h expected %h", cpu_rdata, cpu_model); end
    g = pop_grant(c);
    checks++; if (g !== 1'b1) begin errors++; $display("FAIL ext_write_owner: got %b expected 1", g); end
    tick();
    checks++; if ({ext_ack, grant_ext, busy} !== 3'b000) begin errors++; $display("FAIL ext_write_pulse: got %b expected 000", {ext_ack, grant_ext, busy}); end
    issue_cpu(1'b0, 16'h0200, 16'h0);
    wait_ack(1'b0, 20, n, got); cpu_req = 1'b0;
    exp = pop_cpu();
    checks++; if (!got || cpu_rdata !== exp) begin errors++; $display("FAIL ext_write_readback: got %h ack=%b expected %h", cpu_rdata, got, exp); end
    g = pop_grant(c);
    tick();
  endtask

  task automatic test_simultaneous();
    int n, c0, c1; bit got; logic [15:0] exp; logic g0, g1;
    issue_cpu(1'b0, 16'h0021, 16'h0);
    issue_ext(1'b0, 16'h0042, 16'h0);
    wait_ack(1'b0, 20, n, got); cpu_req = 1'b0;
    checks++; if ({got, ext_ack} !== 2'b10) begin errors++; $display("FAIL sim_cpu_first: got %b expected 10", {got, ext_ack}); end
    exp = pop_cpu();
    checks++; if (cpu_rdata !== exp) begin errors++; $display("FAIL sim_cpu_rdata: got %h expected %h", cpu_rdata, exp); end
    wait_ack(1'b1, 20, n, got); ext_req = 1'b0;
    checks++; if (!got || n !== LAT + 2) begin errors++; $display("FAIL sim_ext_ack: got n=%0d ack=%b expected n=%0d ack=1", n, got, LAT + 2); end
    exp = pop_ext();
    checks++; if (ext_rdata !== exp) begin errors++; $display("FAIL sim_ext_rdata: got %h expected %h", ext_rdata, exp); end
    checks++; if (cpu_rdata !== cpu_model) begin errors++; $display("FAIL sim_cpu_hold: got %h expected %h", cpu_rdata, cpu_model); end
    g0 = pop_grant(c0); g1 = pop_grant(c1);
    checks++; if ({g0, g1} !== 2'b01) begin errors++; $display("FAIL sim_grant_order: got %b expected 01", {g0, g1}); end
    checks++; if (c1 - c0 !== LAT + 2) begin errors++; $display("FAIL sim_grant_spacing: got %0d expected %0d", c1 - c0, LAT + 2); end
    tick();
    checks++; if (ext_ack !== 1'b0) begin errors++; $display("FAIL sim_ext_pulse: got %b expected 0", ext_ack); end
  endtask

  task automatic test_starve();
    logic [15:0] exp; logic g;
    logic exp_g [5];
    int exp_total;
`ifdef ARB_STARVE_GUARD_EN
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; exp_total = 5;
`else
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; exp_total = 6;
`endif
    grant_log.delete(); grant_cyc.delete();
    issue_cpu(1'b0, 16'h0030, 16'h0);
    issue_ext(1'b0, 16'h0050, 16'h0);
    for (int c = 0; c < 80 && grant_log.size() < 5; c++) begin
      tick();
      if (cpu_ack) begin
        exp = pop_cpu();
        checks++; if (cpu_rdata !== exp) begin errors++; $display("FAIL starve_cpu_rdata: got %h expected %h", cpu_rdata, exp); end
        push_exp(1'b0, 1'b0, 16'h0030, 16'h0);
      end
      if (ext_ack) begin
        exp = pop_ext();
        checks++; if (ext_rdata !== exp) begin errors++; $display("FAIL starve_ext_rdata: got %h expected %h", ext_rdata, exp); end
        ext_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      g = (i < grant_log.size()) ? grant_log[i] : 1'bx;
      checks++; if (g !== exp_g[i]) begin errors++; $display("FAIL starve_grant_%0d: got %b expected %b", i, g, exp_g[i]); end
    end
    for (int c = 0; c < 60; c++) begin
      tick();
      if (cpu_ack) begin
        exp = pop_cpu();
        checks++; if (cpu_rdata !== exp) begin errors++; $display("FAIL starve_drain_cpu: got %h expected %h", cpu_rdata, exp); end
      end
      if (ext_ack) begin
        exp = pop_ext();
        checks++; if (ext_rdata !== exp) begin errors++; $display("FAIL starve_drain_ext: got %h expected %h", ext_rdata, exp); end
        ext_req = 1'b0;
      end
      if (!busy && !ext_req && cpu_exp_q.size() == 0 && ext_exp_q.size() == 0) break;
    end
    checks++; if (cpu_exp_q.size() + ext_exp_q.size() != 0) begin errors++;
      $display("FAIL starve_pending: got %0d outstanding expected 0", cpu_exp_q.size() + ext_exp_q.size()); end
    checks++; if (grant_log.size() != exp_total) begin errors++;
      $display("FAIL starve_total_grants: got %0d expected %0d", grant_log.size(), exp_total); end
    if (grant_log.size() == 6) begin
      checks++; if (grant_log[5] !== 1'b1) begin errors++; $display("FAIL starve_ext_late: got %b expected 1", grant_log[5]); end
    end
    grant_log.delete(); grant_cyc.delete();
  endtask

  task automatic test_drop_mid();
    int n = 0, extra = 0; bit got; logic [15:0] exp;
    grant_log.delete(); grant_cyc.delete();
    issue_ext(1'b0, 16'h0077, 16'h0);
    while (!busy && n < 10) begin tick(); n++; end
    ext_req = 1'b0;
    wait_ack(1'b1, 20, n, got);
    checks++; if (!got) begin errors++; $display("FAIL drop_ack: got timeout expected ack"); end
    exp = pop_ext();
    checks++; if (ext_rdata !== exp) begin errors++; $display("FAIL drop_rdata: got %h expected %h", ext_rdata, exp); end
    repeat (LAT + 4) begin tick(); if (ext_ack || cpu_ack) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("FAIL drop_extra_ack: got %0d expected 0", extra); end
    checks++; if (busy !== 1'b0 || grant_log.size() != 1) begin errors++;
      $display("FAIL drop_idle: got busy=%b grants=%0d expected busy=0 grants=1", busy, grant_log.size()); end
  endtask

  task automatic test_reset_mid();
    int n = 0, acks = 0; bit got; logic [15:0] exp;
    cpu_we = 1'b1; cpu_addr = 16'h0005; cpu_wdata = 16'h5555; cpu_req = 1'b1;
    while (!mem_we && n < 10) begin tick(); n++; end
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rstmid_we_start: got %b expected 1", mem_we); end
    #1 Reset = 1'b1;
    #1;
    checks++; if ({mem_we, mem_re, busy, cpu_ack, ext_ack, grant_ext} !== 6'b0) begin errors++;
      $display("FAIL rstmid_ctrl: got %b expected 000000", {mem_we, mem_re, busy, cpu_ack, ext_ack, grant_ext}); end
    checks++; if ({cpu_rdata, ext_rdata} !== 32'h0) begin errors++;
      $display("FAIL rstmid_rdata: got %h/%h expected 0000/0000", cpu_rdata, ext_rdata); end
    cpu_model = '0; ext_model = '0; cpu_req = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    repeat (LAT + 4) begin tick(); if (cpu_ack || ext_ack) acks++; end
    checks++; if (acks !== 0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_no_ack: got acks=%0d busy=%b expected 0/0", acks, busy); end
    issue_cpu(1'b0, 16'h0021, 16'h0);
    wait_ack(1'b0, 20, n, got); cpu_req = 1'b0;
    exp = pop_cpu();
    checks++; if (!got || cpu_rdata !== exp) begin errors++; $display("FAIL rstmid_recover: got %h ack=%b expected %h", cpu_rdata, got, exp); end
    tick();
  endtask

  initial begin
    test_reset();
    test_lat1_read();
    test_cpu_read();
    test_ext_write();
    test_simultaneous();
    test_starve();
    test_drop_mid();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
